// File: rtl/nvram_pkg.sv
// nvram_pkg: shared definitions for the NVRAM responder.
//   - drain_state_e  : posted-write drain FSM states
//   - RD_LATENCY     : cycles from read request to response
//   - WP_*_DEFAULT   : default write-protect window (inclusive word addresses)
//   - RD_OOR_VALUE   : data returned for an out-of-range read
package nvram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROG   = 2'd1,
        COMMIT = 2'd2
    } drain_state_e;

    localparam int unsigned RD_LATENCY       = 2;
    localparam logic [31:0] WP_BASE_DEFAULT  = 32'h0000_0100;
    localparam logic [31:0] WP_LIMIT_DEFAULT = 32'h0000_01FF;
    localparam logic [31:0] RD_OOR_VALUE     = 32'h0000_0000;

endpackage

// File: rtl/nvram_wbuf.sv
// nvram_wbuf: posted-write circular FIFO of {word address, data}.
//   clk_i, reset_n_i          : clock, async active-low reset (empties the FIFO)
//   push_i/push_addr_i/_data_i: enqueue at tail (caller guarantees not full)
//   pop_i                     : dequeue head (caller guarantees not empty)
//   head_addr_o/head_data_o   : oldest entry, the next one to be programmed
//   count_o                   : number of valid entries
//   lookup_addr_i             : read address to forward against
//   hit_o/hit_data_o          : youngest valid entry matching lookup_addr_i
module nvram_wbuf #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned AW      = 12
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       push_i,
    input  logic [AW-1:0]              push_addr_i,
    input  logic [31:0]                push_data_i,
    input  logic                       pop_i,
    output logic [AW-1:0]              head_addr_o,
    output logic [31:0]                head_data_o,
    output logic [$clog2(ENTRIES):0]   count_o,
    input  logic [AW-1:0]              lookup_addr_i,
    output logic                       hit_o,
    output logic [31:0]                hit_data_o
);

    localparam int unsigned PW = $clog2(ENTRIES);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] addr_q [ENTRIES];
    logic [31:0]   data_q [ENTRIES];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = pop_i  ? head_q + 1'b1 : head_q;
        tail_d  = push_i ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: validity is carried by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    // Walk from oldest to youngest so the last match found is the youngest.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign count_o     = count_q;

endmodule

// File: rtl/nvram_responder.sv
// nvram_responder: memory-side responder for the shared 32-bit NVRAM bus.
//   clk, reset_n              : clock, async active-low reset
//   nvram_rd_*                : read request (addr, en) and response (data, valid)
//   nvram_wr_*                : write request (addr, en, data) into the posted buffer
//   wp_lock_req / wp_locked   : one-way lock of the protected key window
//   wr_buf_full / wr_busy     : posted buffer full / drain activity
//   flag_clr                  : clears the sticky error flags below
//   wr_overflow, wp_violation, addr_error : sticky error flags
module nvram_responder
    import nvram_pkg::*;
#(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned WBUF_DEPTH = 4,
    parameter int unsigned WR_CYCLES  = 16,
    parameter logic [31:0] WP_BASE    = WP_BASE_DEFAULT,
    parameter logic [31:0] WP_LIMIT   = WP_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] nvram_rd_addr,
    input  logic        nvram_rd_en,
    output logic [31:0] nvram_rd_data,
    output logic        nvram_rd_valid,
    input  logic [31:0] nvram_wr_addr,
    input  logic        nvram_wr_en,
    input  logic [31:0] nvram_wr_data,
    input  logic        wp_lock_req,
    output logic        wp_locked,
    output logic        wr_buf_full,
    output logic        wr_busy,
    input  logic        flag_clr,
    output logic        wr_overflow,
    output logic        wp_violation,
    output logic        addr_error
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(WBUF_DEPTH) + 1;
    localparam int unsigned TW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam int unsigned PD = RD_LATENCY - 1;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   arr_rd_q;

    logic [AW-1:0] head_addr;
    logic [31:0]   head_data, fwd_data, rd_resolved;
    logic [CW-1:0] buf_count;
    logic          fwd_hit, buf_full, commit, push;
    logic          rd_oor, wr_oor, wr_blocked;

    drain_state_e  state_q, state_d;
    logic [TW-1:0] prog_cnt_q, prog_cnt_d;

    logic          s1_valid_q, s1_oor_q, s1_hit_q;
    logic [31:0]   s1_fwd_q;
    logic [PD-1:0]        rd_valid_q;
    logic [PD-1:0][31:0]  rd_data_q;

    logic wp_locked_q, wp_locked_d;
    logic wr_overflow_q, wr_overflow_d;
    logic wp_violation_q, wp_violation_d;
    logic addr_error_q, addr_error_d;

    nvram_wbuf #(
        .ENTRIES (WBUF_DEPTH),
        .AW      (AW)
    ) u_wbuf (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .push_i        (push),
        .push_addr_i   (nvram_wr_addr[AW-1:0]),
        .push_data_i   (nvram_wr_data),
        .pop_i         (commit),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .count_o       (buf_count),
        .lookup_addr_i (nvram_rd_addr[AW-1:0]),
        .hit_o         (fwd_hit),
        .hit_data_o    (fwd_data)
    );

    // Full is judged on the registered count, so a same-cycle drain never
    // makes room for an incoming write.
    always_comb begin
        rd_oor     = nvram_rd_addr >= DEPTH;
        wr_oor     = nvram_wr_addr >= DEPTH;
        buf_full   = buf_count == CW'(WBUF_DEPTH);
        wr_blocked = wp_locked_q && (nvram_wr_addr >= WP_BASE) && (nvram_wr_addr <= WP_LIMIT);
        push       = nvram_wr_en && !wr_oor && !wr_blocked && !buf_full;

        wp_locked_d    = wp_locked_q | wp_lock_req;
        addr_error_d   = (addr_error_q & ~flag_clr)
                       | (nvram_rd_en & rd_oor) | (nvram_wr_en & wr_oor);
        wp_violation_d = (wp_violation_q & ~flag_clr)
                       | (nvram_wr_en & ~wr_oor & wr_blocked);
        wr_overflow_d  = (wr_overflow_q & ~flag_clr)
                       | (nvram_wr_en & ~wr_oor & ~wr_blocked & buf_full);
    end

    // A write pushed during COMMIT keeps the FSM in PROG rather than idling.
    always_comb begin
        state_d    = state_q;
        prog_cnt_d = prog_cnt_q;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_count != '0) begin
                    state_d    = PROG;
                    prog_cnt_d = TW'(WR_CYCLES - 1);
                end
            end
            PROG: begin
                if (prog_cnt_q == '0) begin
                    state_d = COMMIT;
                end else begin
                    prog_cnt_d = prog_cnt_q - 1'b1;
                end
            end
            COMMIT: begin
                commit = 1'b1;
                if ((buf_count > CW'(1)) || push) begin
                    state_d    = PROG;
                    prog_cnt_d = TW'(WR_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            prog_cnt_q     <= '0;
            wp_locked_q    <= 1'b0;
            addr_error_q   <= 1'b0;
            wp_violation_q <= 1'b0;
            wr_overflow_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            prog_cnt_q     <= prog_cnt_d;
            wp_locked_q    <= wp_locked_d;
            addr_error_q   <= addr_error_d;
            wp_violation_q <= wp_violation_d;
            wr_overflow_q  <= wr_overflow_d;
        end
    end

    // Nonvolatile array: never reset. The read port samples the pre-commit
    // value on a colliding edge; forwarding from the still-present head entry
    // supplies the committed value in that case.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[head_addr] <= head_data;
        end
        if (nvram_rd_en) begin
            arr_rd_q <= mem_q[nvram_rd_addr[AW-1:0]];
        end
    end

    // The forwarding lookup happens in the request cycle, so a write accepted
    // in that same cycle is not yet visible to the read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_oor_q   <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_fwd_q   <= '0;
        end else begin
            s1_valid_q <= nvram_rd_en;
            if (nvram_rd_en) begin
                s1_oor_q <= rd_oor;
                s1_hit_q <= fwd_hit;
                s1_fwd_q <= fwd_data;
            end
        end
    end

    assign rd_resolved = s1_oor_q ? RD_OOR_VALUE : (s1_hit_q ? s1_fwd_q : arr_rd_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q[0] <= s1_valid_q;
            if (s1_valid_q) begin
                rd_data_q[0] <= rd_resolved;
            end
            for (int k = 1; k < int'(PD); k++) begin
                rd_valid_q[k] <= rd_valid_q[k-1];
                rd_data_q[k]  <= rd_data_q[k-1];
            end
        end
    end

    assign nvram_rd_valid = rd_valid_q[PD-1];
    assign nvram_rd_data  = rd_data_q[PD-1];
    assign wp_locked      = wp_locked_q;
    assign wr_buf_full    = buf_full;
    assign wr_busy        = (buf_count != '0) || (state_q != IDLE);
    assign wr_overflow    = wr_overflow_q;
    assign wp_violation   = wp_violation_q;
    assign addr_error     = addr_error_q;

endmodule
